sr_pipe: RTL and testbench
==========================

Name: sr_pipe

Overview:
- Pipelined right-shift unit; the counterpart to the processor's combinational left barrel shifter.
- Serves the srl and sra datapath ops.
- Shift decomposed into 5 registered stages (16, 8, 4, 2, 1), one stage per cycle.
- Valid/ready handshake on both sides so the execute stage can stall it; a destination tag travels with each operand.

Parameters:
- WIDTH, 32, data width; shift amount width fixed at 5 bits; WIDTH must be 32.
- TAG_W, 5, width of the sideband tag (destination register index).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  unit can accept an operand this cycle.
- in_data  input  WIDTH  value to shift.
- in_shamt  input  5  shift amount, 0-31.
- in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync release on clock): all stage valid bits 0; out_valid=0, out_data=0, out_tag=0; in_ready=1 once reset deasserts. Reset mid-operation discards all in-flight operands; no partial result is ever emitted.
- Each of stages S0..S4 registers: valid, data, remaining shamt bits, fill bit, mode, tag.
- Fill bit = in_arith & in_data[31], captured at S0 and carried through all stages.
- Stage Sk shift:
  - Shifts right by 16>>k when shamt bit (4-k) is 1; otherwise passes data through.
  - Vacated MSBs take the carried fill bit.
- Output register is S4; out_* are driven directly from S4.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Advance rule (per stage):
  - Sk loads from Sk-1 when Sk is empty or Sk is emptying this cycle.
  - S4 empties on an output transfer.
  - in_ready = S0 empty or S0 advancing.
  - Bubbles collapse.
  - Stalls are not combinational from out_ready to in_valid; in_ready depends only on stage state and out_ready.
- Latency: an operand accepted in cycle N appears on out_valid in cycle N+5 if there is no backpressure.
- Throughput: 1 result/cycle sustained. A simultaneous accept and emit with a full pipe and out_ready=1 is legal and loses nothing.
- Capacity: 5 operands in flight. With out_ready=0 held, in_ready drops after the 5th accept and the pipe holds all data stable.
- out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- Boundary cases:
  - shamt=0: output = input, for both modes.
  - shamt=31 arithmetic with negative input: 0xFFFFFFFF.
  - shamt=31 logical: bit 0 = input bit 31.
- in_data, in_shamt, in_arith and in_tag are ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: SR_PIPE_ROTATE_EN.
- Defined:
  - Adds input port in_rot (1 bit).
  - When in_rot=1, vacated MSBs take the bits shifted out of that stage (rotate right); in_arith is ignored.
  - Mode carried per stage with the operand.
- Undefined:
  - Port absent; rotate logic not built.
  - Behaviour exactly as above.

Test Plan:
- Reset with in_valid=1 present: out_valid stays 0; after release, in_data=0x80000000, shamt=4, arith=0 -> out_data=0x08000000 exactly 5 cycles after accept.
- Arithmetic mode: 0x80000000, shamt=4 -> 0xF8000000; 0xFFFF0000, shamt=31 -> 0xFFFFFFFF; shamt=0 on 0x12345678 -> 0x12345678.
- Back-to-back 8 operands with out_ready=1 and tags 0-7 -> 8 results on consecutive cycles, tags in order, values match the reference model.
- Hold out_ready=0 and push 7 operands -> exactly 5 accepted, in_ready=0, out_data stable. Release -> remaining operands drain in order with no loss or duplication.
- Assert reset_n=0 mid-stream with 3 operands in flight -> out_valid=0 immediately (async). After release, no stale result appears.
- With SR_PIPE_ROTATE_EN: 0x00000001, shamt=1, in_rot=1 -> 0x80000000; 0x12345678, shamt=8 -> 0x78123456.

Source files
------------

// File: rtl/sr_pipe.sv
// rtl/sr_pipe.sv - five-stage pipelined right shifter (srl/sra), optional rotate under SR_PIPE_ROTATE_EN

module sr_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_shamt,
  input  logic             in_arith,
`ifdef SR_PIPE_ROTATE_EN
  input  logic             in_rot,
`endif
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NS = 5;

  // One conditional right shift; the upper half of the concatenation supplies
  // the vacated MSBs (fill copies, or the operand itself when rotating).
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic             en,
    input int               amt,
    input logic             fill,
    input logic             rot
  );
    logic [2*WIDTH-1:0] cat;
    cat = {(rot ? d : {WIDTH{fill}}), d} >> amt;
    return en ? cat[WIDTH-1:0] : d;
  endfunction

  // Stage state; shamt keeps the not-yet-applied bits MSB-aligned so every
  // stage after S0 consumes bit 3 of its predecessor.
  logic [NS-1:0]    valid_q, valid_d;
  logic [WIDTH-1:0] data_q  [NS];
  logic [WIDTH-1:0] data_d  [NS];
  logic [3:0]       shamt_q [NS];
  logic [3:0]       shamt_d [NS];
  logic [TAG_W-1:0] tag_q   [NS];
  logic [TAG_W-1:0] tag_d   [NS];
  logic [NS-1:0]    fill_q, fill_d;
`ifdef SR_PIPE_ROTATE_EN
  logic [NS-1:0]    rot_q, rot_d;
`endif
  logic [NS-1:0]    adv;

  // A stage may load when it or any stage downstream of it has room.
  always_comb begin
    adv[4] = out_ready | ~valid_q[4];
    adv[3] = out_ready | ~(&valid_q[4:3]);
    adv[2] = out_ready | ~(&valid_q[4:2]);
    adv[1] = out_ready | ~(&valid_q[4:1]);
    adv[0] = out_ready | ~(&valid_q[4:0]);
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[NS-1];
  assign out_data  = data_q[NS-1];
  assign out_tag   = tag_q[NS-1];

  // Next-state for all stages: S0 captures the operand, Sk takes Sk-1.
  always_comb begin
    logic r0;
    logic f0;
    logic rk;
    valid_d = valid_q;
    fill_d  = fill_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    tag_d   = tag_q;
`ifdef SR_PIPE_ROTATE_EN
    rot_d   = rot_q;
    r0      = in_rot;
`else
    r0      = 1'b0;
`endif
    f0 = ~r0 & in_arith & in_data[WIDTH-1];
    rk = 1'b0;

    if (adv[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0]  = shift_stage(in_data, in_shamt[4], 16, f0, r0);
        shamt_d[0] = in_shamt[3:0];
        tag_d[0]   = in_tag;
        fill_d[0]  = f0;
`ifdef SR_PIPE_ROTATE_EN
        rot_d[0]   = r0;
`endif
      end
    end

    for (int k = 1; k < NS; k++) begin
`ifdef SR_PIPE_ROTATE_EN
      rk = rot_q[k-1];
`endif
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k]  = shift_stage(data_q[k-1], shamt_q[k-1][3], 16 >> k, fill_q[k-1], rk);
          shamt_d[k] = shamt_q[k-1] << 1;
          tag_d[k]   = tag_q[k-1];
          fill_d[k]  = fill_q[k-1];
`ifdef SR_PIPE_ROTATE_EN
          rot_d[k]   = rot_q[k-1];
`endif
        end
      end
    end
  end

  // Pipeline registers; reset drops every in-flight operand.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      fill_q  <= '0;
`ifdef SR_PIPE_ROTATE_EN
      rot_q   <= '0;
`endif
      for (int k = 0; k < NS; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      fill_q  <= fill_d;
`ifdef SR_PIPE_ROTATE_EN
      rot_q   <= rot_d;
`endif
      for (int k = 0; k < NS; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

endmodule

// File: tb/tb_sr_pipe.sv
// tb/tb_sr_pipe.sv - scoreboard testbench for sr_pipe

module tb_sr_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [4:0]       in_shamt = '0;
  logic             in_arith = 1'b0;
  logic             in_rot = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  logic [TAG_W+WIDTH-1:0] sb_q[$];
  int out_cycles[$];

  sr_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_shamt(in_shamt),
    .in_arith(in_arith),
`ifdef SR_PIPE_ROTATE_EN
    .in_rot(in_rot),
`endif
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish earlier");
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic a, input logic r);
    logic [63:0] dd;
    if (r) begin
      dd = {d, d} >> s;
      return dd[31:0];
    end else if (a) begin
      return $signed(d) >>> s;
    end
    return d >> s;
  endfunction

  task automatic set_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                        input logic r, input logic [4:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_arith = a;
    in_rot   = r;
    in_tag   = t;
  endtask

  // One clock: records an accepted operand's expected result, checks any emitted result.
  task automatic tick(input logic [31:0] exp);
    logic [TAG_W+WIDTH-1:0] e;
    #1;
    if (in_valid && in_ready) begin
      sb_q.push_back({in_tag, exp});
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      checks++;
      out_cnt++;
      out_cycles.push_back(cyc);
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got data=%h tag=%0d, required no result", out_data, out_tag);
      end else begin
        e = sb_q.pop_front();
        if (out_data !== e[WIDTH-1:0] || out_tag !== e[TAG_W+WIDTH-1:WIDTH]) begin
          errors++;
          $display("FAIL sb_result: got data=%h tag=%0d, required data=%h tag=%0d",
                   out_data, out_tag, e[WIDTH-1:0], e[TAG_W+WIDTH-1:WIDTH]);
        end
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    out_ready = 1'b1;
    set_op(32'hDEADBEEF, 5'd3, 1'b1, 1'b0, 5'd9);
    repeat (3) begin
      @(negedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b data=%h tag=%0d, required 0/0/0", out_valid, out_data, out_tag);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(negedge clock);
    set_op(32'h80000000, 5'd4, 1'b0, 1'b0, 5'd3);
    tick(32'h08000000);
    in_valid = 1'b0;
    repeat (3) tick(32'h0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got out_valid=%b 4 cycles after accept, required 0", out_valid);
    end
    tick(32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h08000000 || out_tag !== 5'd3) begin
      errors++;
      $display("FAIL latency_5: got valid=%b data=%h tag=%0d, required 1/08000000/3", out_valid, out_data, out_tag);
    end
    tick(32'h0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_arith();
    logic [31:0] d_t[6]   = '{32'h80000000, 32'hFFFF0000, 32'h12345678, 32'h12345678, 32'h80000000, 32'h7FFFFFFF};
    logic [4:0]  s_t[6]   = '{5'd4, 5'd31, 5'd0, 5'd0, 5'd31, 5'd31};
    logic        a_t[6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] e_t[6]   = '{32'hF8000000, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h00000001, 32'h00000000};
    int base;
    int n;
    base = out_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_op(d_t[i], s_t[i], a_t[i], 1'b0, 5'(i + 1));
      tick(e_t[i]);
    end
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick(32'h0);
      n++;
    end
    checks++;
    if (out_cnt - base != 6 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL arith_count: got %0d results, %0d pending, required 6 and 0", out_cnt - base, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [4:0]  s;
    logic        a;
    int base;
    int n;
    base = out_cnt;
    out_ready = 1'b1;
    out_cycles.delete();
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      a = 1'($urandom_range(0, 1));
      if (i == 0) d[31] = 1'b1;
      set_op(d, s, a, 1'b0, 5'(i));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready: got %b at operand %0d, required 1", in_ready, i);
      end
      tick(model(d, s, a, 1'b0));
    end
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick(32'h0);
      n++;
    end
    checks++;
    if (out_cnt - base != 8 || out_cycles.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 8", out_cnt - base);
    end else begin
      checks++;
      if (out_cycles[7] - out_cycles[0] != 7) begin
        errors++;
        $display("FAIL b2b_spacing: got span %0d cycles, required 7", out_cycles[7] - out_cycles[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d_t[7];
    logic [4:0]  s_t[7];
    logic        a_t[7];
    int i;
    int n;
    int prev;
    int base_acc;
    int base_out;
    for (int k = 0; k < 7; k++) begin
      d_t[k] = $urandom;
      s_t[k] = 5'($urandom_range(0, 31));
      a_t[k] = 1'($urandom_range(0, 1));
    end
    base_acc = acc_cnt;
    base_out = out_cnt;
    out_ready = 1'b0;
    i = 0;
    for (int c = 0; c < 10; c++) begin
      set_op(d_t[i], s_t[i], a_t[i], 1'b0, 5'(10 + i));
      prev = acc_cnt;
      tick(model(d_t[i], s_t[i], a_t[i], 1'b0));
      if (acc_cnt != prev) i++;
      if (c == 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== model(d_t[0], s_t[0], a_t[0], 1'b0) || out_tag !== 5'd10) begin
          errors++;
          $display("FAIL bp_head_early: got valid=%b data=%h tag=%0d, required 1/%h/10",
                   out_valid, out_data, out_tag, model(d_t[0], s_t[0], a_t[0], 1'b0));
        end
      end
    end
    #1;
    checks++;
    if (acc_cnt - base_acc != 5 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_capacity: got %0d accepted in_ready=%b, required 5 and 0", acc_cnt - base_acc, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== model(d_t[0], s_t[0], a_t[0], 1'b0) || out_tag !== 5'd10) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b data=%h tag=%0d, required 1/%h/10",
               out_valid, out_data, out_tag, model(d_t[0], s_t[0], a_t[0], 1'b0));
    end
    out_ready = 1'b1;
    n = 0;
    while ((i < 7 || sb_q.size() != 0) && n < 30) begin
      if (i < 7) begin
        set_op(d_t[i], s_t[i], a_t[i], 1'b0, 5'(10 + i));
        prev = acc_cnt;
        tick(model(d_t[i], s_t[i], a_t[i], 1'b0));
        if (acc_cnt != prev) i++;
      end else begin
        in_valid = 1'b0;
        tick(32'h0);
      end
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cnt - base_acc != 7 || out_cnt - base_out != 7 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d accepted %0d emitted %0d pending, required 7/7/0",
               acc_cnt - base_acc, out_cnt - base_out, sb_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    int base;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(32'hF0F0F0F0 ^ 32'(i), 5'(i + 1), 1'b1, 1'b0, 5'(20 + i));
      tick(model(32'hF0F0F0F0 ^ 32'(i), 5'(i + 1), 1'b1, 1'b0));
    end
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      tick(32'h0);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill: got out_valid=%b, required 1 before reset", out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin
      errors++;
      $display("FAIL mid_async: got valid=%b data=%h tag=%0d, required 0/0/0", out_valid, out_data, out_tag);
    end
    sb_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    base = out_cnt;
    repeat (10) tick(32'h0);
    checks++;
    if (out_cnt != base) begin
      errors++;
      $display("FAIL mid_stale: got %0d results after reset, required 0", out_cnt - base);
    end
  endtask

`ifdef SR_PIPE_ROTATE_EN
  task automatic test_rotate();
    int n;
    int base;
    base = out_cnt;
    out_ready = 1'b1;
    set_op(32'h00000001, 5'd1, 1'b0, 1'b1, 5'd1);
    tick(32'h80000000);
    set_op(32'h12345678, 5'd8, 1'b0, 1'b1, 5'd2);
    tick(32'h78123456);
    set_op(32'h80000000, 5'd4, 1'b1, 1'b1, 5'd3);
    tick(32'h08000000);
    in_valid = 1'b0;
    in_rot = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick(32'h0);
      n++;
    end
    checks++;
    if (out_cnt - base != 3 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL rot_count: got %0d results, required 3", out_cnt - base);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
`ifdef SR_PIPE_ROTATE_EN
    test_rotate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
